// File: rtl/sram_dual_port_be.sv
// Single-clock true dual-port SRAM with per-port byte enables, selectable
// read-during-write behaviour, optional output register, A-over-B write
// priority with a collision flag, and a clear-on-reset sequencer.
module sram_dual_port_be #(
    parameter int nrOfAddressBits = 12,
    parameter int nrOfBytes       = 4,
    parameter int readMode        = 0,
    parameter int outputRegister  = 0,
    parameter int clearOnReset    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       ready,
    input  logic                       enableA,
    input  logic [nrOfBytes-1:0]       byteEnableA,
    input  logic [nrOfAddressBits-1:0] addressA,
    input  logic [8*nrOfBytes-1:0]     dataInA,
    output logic [8*nrOfBytes-1:0]     dataOutA,
    output logic                       dataValidA,
    input  logic                       enableB,
    input  logic [nrOfBytes-1:0]       byteEnableB,
    input  logic [nrOfAddressBits-1:0] addressB,
    input  logic [8*nrOfBytes-1:0]     dataInB,
    output logic [8*nrOfBytes-1:0]     dataOutB,
    output logic                       dataValidB,
    output logic                       collision
);

    localparam int W     = 8 * nrOfBytes;
    localparam int AW    = nrOfAddressBits;
    localparam int DEPTH = 2 ** nrOfAddressBits;

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [W-1:0]  mem [DEPTH];
    state_t        state, state_next;
    logic [AW-1:0] clr_addr;

    logic          accept_a, accept_b;
    logic          write_a, write_b;
    logic [W-1:0]  merged_a, merged_b;
    logic [W-1:0]  read_a, read_b;

    logic          vld_p0_a, vld_p0_b;
    logic [W-1:0]  data_p0_a, data_p0_b;

    assign ready    = (state == IDLE);
    assign accept_a = ready && enableA && !reset;
    assign accept_b = ready && enableB && !reset;
    assign write_a  = accept_a && (|byteEnableA);
    assign write_b  = accept_b && (|byteEnableB);

    // Word at 'addr' as it will look after this cycle's writes: per byte,
    // port A wins, then port B, otherwise the stored byte is kept.
    function automatic logic [W-1:0] merge_word(input logic [W-1:0] old,
                                                input logic [AW-1:0] addr);
        logic [W-1:0] w;
        w = old;
        for (int i = 0; i < nrOfBytes; i++) begin
            if (write_a && (addressA == addr) && byteEnableA[i])
                w[8*i +: 8] = dataInA[8*i +: 8];
            else if (write_b && (addressB == addr) && byteEnableB[i])
                w[8*i +: 8] = dataInB[8*i +: 8];
        end
        return w;
    endfunction

    // Post-write words for both addresses and the read data each port returns
    always_comb begin
        merged_a = merge_word(mem[addressA], addressA);
        merged_b = merge_word(mem[addressB], addressB);
        read_a   = (readMode != 0) ? merged_a : mem[addressA];
        read_b   = (readMode != 0) ? merged_b : mem[addressB];
    end

    // Clear sequencer state register; reset (re)starts the clear when enabled
    always_ff @(posedge clock) begin
        if (reset)
            state <= (clearOnReset != 0) ? CLEAR : IDLE;
        else
            state <= state_next;
    end

    // Clear sequencer next state: leave CLEAR after the last address is written
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_addr == {AW{1'b1}}) state_next = IDLE;
            default: state_next = state;
        endcase
    end

    // Clear address counter walks the whole array once
    always_ff @(posedge clock) begin
        if (reset)
            clr_addr <= '0;
        else if (state == CLEAR)
            clr_addr <= clr_addr + 1'b1;
    end

    // Array writes: clearing zeroes one word per cycle, otherwise both ports
    // write their merged words (identical when the addresses match)
    always_ff @(posedge clock) begin
        if (!reset && state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            if (write_b) mem[addressB] <= merged_b;
            if (write_a) mem[addressA] <= merged_a;
        end
    end

    // Port A read pipeline: optional extra stage, output holds when idle
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0_a   <= 1'b0;
            data_p0_a  <= '0;
            dataValidA <= 1'b0;
            dataOutA   <= '0;
        end else begin
            vld_p0_a <= accept_a;
            if (accept_a) data_p0_a <= read_a;
            if (outputRegister == 0) begin
                dataValidA <= accept_a;
                if (accept_a) dataOutA <= read_a;
            end else begin
                dataValidA <= vld_p0_a;
                if (vld_p0_a) dataOutA <= data_p0_a;
            end
        end
    end

    // Port B read pipeline: optional extra stage, output holds when idle
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0_b   <= 1'b0;
            data_p0_b  <= '0;
            dataValidB <= 1'b0;
            dataOutB   <= '0;
        end else begin
            vld_p0_b <= accept_b;
            if (accept_b) data_p0_b <= read_b;
            if (outputRegister == 0) begin
                dataValidB <= accept_b;
                if (accept_b) dataOutB <= read_b;
            end else begin
                dataValidB <= vld_p0_b;
                if (vld_p0_b) dataOutB <= data_p0_b;
            end
        end
    end

    // Collision flag: both ports wrote at least one common byte of one word
    always_ff @(posedge clock) begin
        if (reset)
            collision <= 1'b0;
        else
            collision <= write_a && write_b && (addressA == addressB) &&
                         (|(byteEnableA & byteEnableB));
    end

endmodule

// File: tb/tb_sram_dual_port_be.sv
// Directed bench for sram_dual_port_be: two instances share the stimulus,
// one read-first with latency 1, one write-first with latency 2.
module tb_sram_dual_port_be;

    logic        clock;
    logic        reset;
    logic        enableA, enableB;
    logic [3:0]  byteEnableA, byteEnableB;
    logic [3:0]  addressA, addressB;
    logic [31:0] dataInA, dataInB;

    logic        ready0, dva0, dvb0, col0;
    logic [31:0] doa0, dob0;
    logic        ready1, dva1, dvb1, col1;
    logic [31:0] doa1, dob1;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    sram_dual_port_be #(.nrOfAddressBits(4), .nrOfBytes(4), .readMode(0),
                        .outputRegister(0), .clearOnReset(1)) u0 (
        .clock(clock), .reset(reset), .ready(ready0),
        .enableA(enableA), .byteEnableA(byteEnableA), .addressA(addressA),
        .dataInA(dataInA), .dataOutA(doa0), .dataValidA(dva0),
        .enableB(enableB), .byteEnableB(byteEnableB), .addressB(addressB),
        .dataInB(dataInB), .dataOutB(dob0), .dataValidB(dvb0),
        .collision(col0));

    sram_dual_port_be #(.nrOfAddressBits(4), .nrOfBytes(4), .readMode(1),
                        .outputRegister(1), .clearOnReset(1)) u1 (
        .clock(clock), .reset(reset), .ready(ready1),
        .enableA(enableA), .byteEnableA(byteEnableA), .addressA(addressA),
        .dataInA(dataInA), .dataOutA(doa1), .dataValidA(dva1),
        .enableB(enableB), .byteEnableB(byteEnableB), .addressB(addressB),
        .dataInB(dataInB), .dataOutB(dob1), .dataValidB(dvb1),
        .collision(col1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        enableA = 1'b1; byteEnableA = be; addressA = a; dataInA = d;
        tick();
        enableA = 1'b0; byteEnableA = 4'b0000;
    endtask

    task automatic rd_b(input string tag, input logic [3:0] a,
                        input logic [31:0] e0, input logic [31:0] e1);
        enableB = 1'b1; byteEnableB = 4'b0000; addressB = a;
        tick();
        enableB = 1'b0;
        chk({tag, "_u0"}, {31'd0, dvb0, dob0}, {31'd0, 1'b1, e0});
        tick();
        chk({tag, "_u1"}, {31'd0, dvb1, dob1}, {31'd0, 1'b1, e1});
        chk({tag, "_u0_pulse"}, {63'd0, dvb0}, 64'd0);
    endtask

    task automatic wait_ready(inout int n);
        while (ready0 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; enableA = 1'b0; enableB = 1'b0;
        byteEnableA = 4'b0; byteEnableB = 4'b0;
        addressA = 4'd0; addressB = 4'd0; dataInA = 32'd0; dataInB = 32'd0;

        // Reset state
        tick();
        chk("rst_ready", {62'd0, ready0, ready1}, 64'd0);
        chk("rst_valid", {60'd0, dva0, dvb0, dva1, dvb1}, 64'd0);
        chk("rst_data0", {doa0, dob0}, 64'd0);
        chk("rst_data1", {doa1, dob1}, 64'd0);
        chk("rst_coll", {62'd0, col0, col1}, 64'd0);
        reset = 1'b0;
        n = 0;
        wait_ready(n);
        chk("clear_len_first", n, 16);

        // Preload every word with a non-zero pattern
        for (int a = 0; a < 16; a++) wr_a(4'(a), 4'hF, 32'hDEADBEEF);
        tick();
        rd_b("preload", 4'd7, 32'hDEADBEEF, 32'hDEADBEEF);

        // Clear restarted by a second reset at clear cycle 7; accesses ignored while clearing
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("ready_low_after_reset", {63'd0, ready0}, 64'd0);
        n = 0;
        tick(); tick(); n = 2;
        enableA = 1'b1; byteEnableA = 4'hF; addressA = 4'd0; dataInA = 32'h12345678;
        enableB = 1'b1; byteEnableB = 4'h0; addressB = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick(); n++;
            chk("ignored_valid", {60'd0, dva0, dvb0, dva1, dvb1}, 64'd0);
        end
        enableA = 1'b0; byteEnableA = 4'h0; enableB = 1'b0;
        wait_ready(n);
        chk("clear_len_restart", n, 16);
        chk("ready_u1", {63'd0, ready1}, 64'd1);

        // Pipelined readback of the whole array on port A
        for (int a = 0; a <= 16; a++) begin
            enableA = (a < 16); addressA = 4'(a);
            tick();
            if (a < 16) chk($sformatf("clr_u0_%0d", a), {31'd0, dva0, doa0}, {31'd0, 1'b1, 32'd0});
            if (a >= 1) chk($sformatf("clr_u1_%0d", a - 1), {31'd0, dva1, doa1}, {31'd0, 1'b1, 32'd0});
        end
        enableA = 1'b0;
        tick();

        // Byte enables
        wr_a(4'd3, 4'hF, 32'h11223344);
        wr_a(4'd3, 4'b0101, 32'hAABBCCDD);
        rd_b("byte_en", 4'd3, 32'h11BB33DD, 32'h11BB33DD);

        // Back-to-back reads and latency
        wr_a(4'd1, 4'hF, 32'h10);
        wr_a(4'd2, 4'hF, 32'h20);
        wr_a(4'd3, 4'hF, 32'h30);
        tick();
        enableB = 1'b1; addressB = 4'd1;
        tick();
        chk("lat_c1_u0", {31'd0, dvb0, dob0}, {31'd0, 1'b1, 32'h10});
        chk("lat_c1_u1", {63'd0, dvb1}, 64'd0);
        addressB = 4'd2;
        tick();
        chk("lat_c2_u0", {31'd0, dvb0, dob0}, {31'd0, 1'b1, 32'h20});
        chk("lat_c2_u1", {31'd0, dvb1, dob1}, {31'd0, 1'b1, 32'h10});
        addressB = 4'd3;
        tick();
        enableB = 1'b0;
        chk("lat_c3_u0", {31'd0, dvb0, dob0}, {31'd0, 1'b1, 32'h30});
        chk("lat_c3_u1", {31'd0, dvb1, dob1}, {31'd0, 1'b1, 32'h20});
        tick();
        chk("lat_c4_u0_hold", {31'd0, dvb0, dob0}, {31'd0, 1'b0, 32'h30});
        chk("lat_c4_u1", {31'd0, dvb1, dob1}, {31'd0, 1'b1, 32'h30});
        tick();
        chk("lat_c5_u1_hold", {31'd0, dvb1, dob1}, {31'd0, 1'b0, 32'h30});

        // Read-during-write, same port and cross port, address 5
        enableA = 1'b1; byteEnableA = 4'hF; addressA = 4'd5; dataInA = 32'hCAFEF00D;
        enableB = 1'b1; byteEnableB = 4'h0; addressB = 4'd5;
        tick();
        enableA = 1'b0; byteEnableA = 4'h0; enableB = 1'b0;
        chk("rdw_a_u0", {31'd0, dva0, doa0}, {31'd0, 1'b1, 32'h0});
        chk("rdw_b_u0", {31'd0, dvb0, dob0}, {31'd0, 1'b1, 32'h0});
        tick();
        chk("rdw_a_u1", {31'd0, dva1, doa1}, {31'd0, 1'b1, 32'hCAFEF00D});
        chk("rdw_b_u1", {31'd0, dvb1, dob1}, {31'd0, 1'b1, 32'hCAFEF00D});
        rd_b("rdw_mem", 4'd5, 32'hCAFEF00D, 32'hCAFEF00D);

        // Collision at address 9
        enableA = 1'b1; byteEnableA = 4'b1100; addressA = 4'd9; dataInA = 32'hAAAAAAAA;
        enableB = 1'b1; byteEnableB = 4'b0110; addressB = 4'd9; dataInB = 32'hBBBBBBBB;
        tick();
        enableA = 1'b0; byteEnableA = 4'h0; enableB = 1'b0; byteEnableB = 4'h0;
        chk("coll_pulse", {62'd0, col0, col1}, 64'd3);
        chk("coll_rd_u0", {doa0, dob0}, 64'd0);
        tick();
        chk("coll_end", {62'd0, col0, col1}, 64'd0);
        chk("coll_rd_u1", {doa1, dob1}, {32'hAAAABB00, 32'hAAAABB00});
        rd_b("coll_mem", 4'd9, 32'hAAAABB00, 32'hAAAABB00);

        // Same address, disjoint bytes: merged, no collision
        enableA = 1'b1; byteEnableA = 4'b0011; addressA = 4'd10; dataInA = 32'hAAAAAAAA;
        enableB = 1'b1; byteEnableB = 4'b1100; addressB = 4'd10; dataInB = 32'hBBBBBBBB;
        tick();
        enableA = 1'b0; byteEnableA = 4'h0; enableB = 1'b0; byteEnableB = 4'h0;
        chk("nocoll", {62'd0, col0, col1}, 64'd0);
        tick();
        rd_b("disjoint_mem", 4'd10, 32'hBBBBAAAA, 32'hBBBBAAAA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
